// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data requests onto one single-ported, variable-latency RAM.
// One RAM transaction is in flight at a time; data wins unless instruction fetch is starving.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ram_ready
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] IBUSY = 2'd1;
    localparam logic [1:0] DBUSY = 2'd2;

    localparam logic [3:0] LimitC = 4'(STARVE_LIMIT);

    logic [1:0]  state_q, state_d;
    logic [3:0]  starve_q, starve_d;
    logic        ram_ren_q, ram_ren_d;
    logic        ram_wen_q, ram_wen_d;
    logic [31:0] ram_addr_q, ram_addr_d;
    logic [31:0] ram_store_q, ram_store_d;

    logic d_req;
    logic i_done;
    logic d_done;

    assign d_req = dREN | dWEN;

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        ram_ren_d   = ram_ren_q;
        ram_wen_d   = ram_wen_q;
        ram_addr_d  = ram_addr_q;
        ram_store_d = ram_store_q;
        case (state_q)
            IDLE: begin
                if (d_req && (starve_q < LimitC)) begin
                    state_d     = DBUSY;
                    // dREN together with dWEN is resolved as a write
                    ram_ren_d   = dREN & ~dWEN;
                    ram_wen_d   = dWEN;
                    ram_addr_d  = daddr;
                    ram_store_d = dstore;
                    if (iREN) begin
                        starve_d = (starve_q == 4'hF) ? starve_q : starve_q + 4'd1;
                    end else begin
                        starve_d = 4'd0;
                    end
                end else if (iREN) begin
                    state_d    = IBUSY;
                    ram_ren_d  = 1'b1;
                    ram_wen_d  = 1'b0;
                    ram_addr_d = iaddr;
                    starve_d   = 4'd0;
                end
            end
            IBUSY, DBUSY: begin
                if (ram_ready) begin
                    state_d   = IDLE;
                    ram_ren_d = 1'b0;
                    ram_wen_d = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                ram_ren_d = 1'b0;
                ram_wen_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            starve_q    <= 4'd0;
            ram_ren_q   <= 1'b0;
            ram_wen_q   <= 1'b0;
            ram_addr_q  <= 32'd0;
            ram_store_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            ram_ren_q   <= ram_ren_d;
            ram_wen_q   <= ram_wen_d;
            ram_addr_q  <= ram_addr_d;
            ram_store_q <= ram_store_d;
        end
    end

    // A withdrawn request still completes on the RAM side but returns nothing.
    assign i_done = (state_q == IBUSY) && ram_ready;
    assign d_done = (state_q == DBUSY) && ram_ready;

    assign iwait = iREN & ~i_done;
    assign iload = (iREN && i_done) ? ramload : 32'd0;
    assign dwait = d_req & ~d_done;
    assign dload = (dREN && !dWEN && d_done) ? ramload : 32'd0;

    assign ramREN   = ram_ren_q;
    assign ramWEN   = ram_wen_q;
    assign ramaddr  = ram_addr_q;
    assign ramstore = ram_store_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the pipeline's instruction-fetch and data-access requests onto one single-ported RAM with variable latency. It sits between the datapath/cache side and the RAM. It serialises requests so that exactly one RAM transaction is outstanding at a time. Data accesses take priority, and a starvation guard guarantees instruction-fetch forward progress. Results return to each requester through a wait/ready handshake.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive data grants allowed while an instruction request waits; legal range 1–15.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- nRST  in  1  asynchronous reset, active-low.
- iREN  in  1  instruction read request; held until iwait low.
- iaddr  in  32  instruction word address.
- iwait  out  1  high while the instruction request is not completing this cycle.
- iload  out  32  instruction data; valid when iREN && !iwait, else 0.
- dREN  in  1  data read request; held until dwait low.
- dWEN  in  1  data write request; held until dwait low.
- daddr  in  32  data address.
- dstore  in  32  write data.
- dwait  out  1  high while the data request is not completing this cycle.
- dload  out  32  read data; valid when dREN && !dwait, else 0.
- ramREN  out  1  registered RAM read strobe.
- ramWEN  out  1  registered RAM write strobe.
- ramaddr  out  32  registered RAM address.
- ramstore  out  32  registered RAM write data.
- ramload  in  32  RAM read data; valid with ram_ready.
- ram_ready  in  1  one-cycle pulse; the current RAM access completes this cycle.

## Operation
- The FSM has three states: IDLE, IBUSY and DBUSY. Reset state is IDLE.
- Grant decision in IDLE each cycle:
  - If a data request (dREN|dWEN) is pending and starve_cnt < STARVE_LIMIT, go to DBUSY.
  - Otherwise, if iREN is set, go to IBUSY.
  - Otherwise, stay in IDLE.
- On a grant, latch the following into the ram* output registers:
  - the address;
  - the store data;
  - the op: ramWEN = dWEN; ramREN = dREN && !dWEN, or 1 for an instruction grant.
- If dREN and dWEN are asserted together, treat the request as a write. This combination is illegal; no error is flagged.
- In IBUSY/DBUSY, hold all ram* registers stable until ram_ready.
  - When ram_ready is seen, clear ramREN/ramWEN and return to IDLE on that edge.
  - There is no direct busy-to-busy transition, so every transaction is followed by one IDLE bubble cycle.
- Completion:
  - In IBUSY && ram_ready: iwait = 0 and iload = ramload.
  - In DBUSY && ram_ready: dwait = 0. dload = ramload for reads; dload = 0 for writes.
- iwait = iREN && !(IBUSY && ram_ready). dwait = (dREN|dWEN) && !(DBUSY && ram_ready). Both are combinational.
- starve_cnt is 4 bits wide and updates only on grant edges:
  - A data grant while iREN is high increments it, saturating at 15.
  - An instruction grant clears it.
  - A data grant while iREN is low clears it.
- Withdrawn request (requester drops its request while in BUSY): the RAM transaction still runs to ram_ready, the result is discarded, and no wait/load outputs assert for it.
- A ram_ready pulse arriving in IDLE is ignored.

## Timing
- Reset values: state IDLE; starve_cnt 0; ramREN 0, ramWEN 0, ramaddr 0, ramstore 0. Outputs then follow from the combinational rules: iwait = iREN, dwait = dREN|dWEN, iload = 0, dload = 0.
- Latency: a request sampled in IDLE at edge N drives the ram* strobes from cycle N+1. Completion occurs in the cycle in which ram_ready is high.
  - Minimum latency is one cycle after the grant, i.e. ram_ready in cycle N+1.
  - Total throughput with zero-wait RAM is one transaction per 2 cycles.
- Asserting nRST mid-transaction immediately forces state IDLE and clears the RAM strobes. The RAM-side transaction is abandoned and the requester sees its wait output held high.
- Simultaneous events:
  - ram_ready together with a new request from the same requester in the same cycle: the new request is treated as the same held request, and it is granted again on the next IDLE cycle.
  - Both requesters pending in IDLE: arbitration uses the starve_cnt value before the update.

## Test plan
- Instruction-only fetch: iREN=1, iaddr=0x40, RAM returns 0xDEADBEEF after 3 cycles -> ramREN=1 with ramaddr=0x40 for 3 cycles; iwait falls for exactly one cycle with iload=0xDEADBEEF; next cycle is IDLE.
- Data priority: iREN and dREN asserted in the same IDLE cycle, daddr=0x100 -> DBUSY granted first; instruction granted after the IDLE bubble; iwait stays high throughout the data access.
- Starvation guard (STARVE_LIMIT=4): dREN held continuously with iREN=1, zero-wait RAM -> exactly 4 data grants, then 1 instruction grant, then data resumes; observed grant pattern D D D D I D.
- Write: dWEN=1, daddr=0x200, dstore=0x12345678 -> ramWEN=1, ramaddr=0x200, ramstore=0x12345678 until ram_ready; dwait low for one cycle with dload=0.
- Reset mid-access: nRST pulled low in DBUSY before ram_ready -> ramREN/ramWEN drop asynchronously, state IDLE, starve_cnt 0; after release the held request is re-granted.
- Spurious/withdrawn: ram_ready pulsed in IDLE -> no output change. iREN dropped during IBUSY -> iwait 0 and iload 0 at completion, FSM returns to IDLE.
